// File: rtl/seq_mult_hs.sv
//-----------------------------------------------------------------------------
// seq_mult_hs
//   Iterative shift-add multiplier with valid/ready handshakes on both sides.
//   Retires R multiplier bits per clock. It can treat the operands as unsigned
//   or as two's complement, chosen per operation.
//
// Parameters
//   M  operand width (>= 2)
//   R  multiplier bits retired per cycle (1, 2 or 4; must divide M)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operand pair valid
//   in_ready     block can accept operands (high only in IDLE)
//   signed_mode  1 = operands are two's complement (sampled on accept)
//   dataA        multiplicand (sampled on accept)
//   dataB        multiplier   (sampled on accept)
//   out_valid    P holds a completed product
//   out_ready    consumer takes P
//   P            2M-bit product (two's complement when signed_mode was 1)
//   dbg_state    current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Once out_valid is high, P and out_valid stay stable until that
// edge. in_ready depends only on the FSM state. out_valid is a register.
// No path runs combinationally from in_valid or out_ready to any output.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module seq_mult_hs #(
    parameter int M = 8,
    parameter int R = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           signed_mode,
    input  logic [M-1:0]   dataA,
    input  logic [M-1:0]   dataB,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*M-1:0] P,
    output logic [1:0]     dbg_state
);

    localparam int STEPS = M / R;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state;
    logic [2*M-1:0] mcand;   // magnitude of A, pre-shifted by k*R
    logic [M-1:0]   mplier;  // magnitude of B, consumed R bits per step from the LSB
    logic [2*M-1:0] acc;
    logic           neg;
    logic [CW-1:0]  cnt;

    logic [M-1:0]   abs_a;
    logic [M-1:0]   abs_b;
    logic [2*M-1:0] pp;
    logic [2*M-1:0] sum;

    // Magnitudes are M-bit unsigned, so -2^(M-1) maps to 2^(M-1) without loss.
    always_comb begin
        abs_a = dataA;
        abs_b = dataB;
        if (signed_mode && dataA[M-1]) abs_a = {M{1'b0}} - dataA;
        if (signed_mode && dataB[M-1]) abs_b = {M{1'b0}} - dataB;
    end

    // The shifting multiplicand and multiplier give the same result as
    // magA * magB[kR +: R] << kR without a variable part-select.
    // The product never exceeds 2^2M, so truncating to 2M bits loses nothing.
    always_comb begin
        pp  = mcand * {{(2*M-R){1'b0}}, mplier[R-1:0]};
        sum = acc + pp;
    end

    assign in_ready  = (state == S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            P         <= '0;
            acc       <= '0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            neg       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{M{1'b0}}, abs_a};
                        mplier <= abs_b;
                        neg    <= signed_mode & (dataA[M-1] ^ dataB[M-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc    <= sum;
                    mcand  <= mcand << R;
                    mplier <= mplier >> R;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Negating a zero magnitude still gives zero.
                        P         <= neg ? ({(2*M){1'b0}} - sum) : sum;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // P is left as is after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_hs.sv
`timescale 1ns/1ps
module tb_seq_mult_hs;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 8x8, R=1 instance
    logic        in_valid, in_ready, signed_mode, out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  dataA, dataB;
    logic [15:0] P;
    logic [1:0]  dbg_state;

    // 16x16, R=4 instance
    logic        in_valid_w, in_ready_w, sm_w, out_valid_w;
    logic        out_ready_w = 1'b1;
    logic [15:0] a_w, b_w;
    logic [31:0] P_w;
    logic [1:0]  dbg_state_w;

    seq_mult_hs #(.M(8), .R(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .signed_mode(signed_mode), .dataA(dataA), .dataB(dataB),
        .out_valid(out_valid), .out_ready(out_ready), .P(P), .dbg_state(dbg_state)
    );

    seq_mult_hs #(.M(16), .R(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .signed_mode(sm_w), .dataA(a_w), .dataB(b_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .P(P_w), .dbg_state(dbg_state_w)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp  = 0;
    int n_err  = 0;
    int n_sent = 0;
    int n_res  = 0;
    int ready_mode = 1;          // 0: hold low, 1: hold high, 2: random
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        longint sa, sb;
        logic [63:0] t;
        sa = sm ? longint'($signed(a)) : longint'({56'b0, a});
        sb = sm ? longint'($signed(b)) : longint'({56'b0, b});
        t  = 64'(sa * sb);
        return t[15:0];
    endfunction

    function automatic logic [31:0] ref16(input logic sm, input logic [15:0] a, input logic [15:0] b);
        longint sa, sb;
        logic [63:0] t;
        sa = sm ? longint'($signed(a)) : longint'({48'b0, a});
        sb = sm ? longint'($signed(b)) : longint'({48'b0, b});
        t  = 64'(sa * sb);
        return t[31:0];
    endfunction

    // ---------------- out_ready driver ----------------
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_result", 64'd1, 64'd0);
            end else begin
                check("P", P, exp_q.pop_front());
                n_res++;
            end
        end
    end

    // ---------------- driver tasks (called at posedge + #1) ----------------
    task automatic send8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1; signed_mode = sm; dataA = a; dataB = b;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            exp_q.push_back(ref8(sm, a, b));
            n_sent++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!in_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("idle_timeout", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic lat_check8();
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check("latency8", {63'd0, out_valid}, {63'd0, (i == 8)});
        end
    endtask

    task automatic run16(input logic sm, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
        int t;
        t = 0;
        in_valid_w = 1'b1; sm_w = sm; a_w = a; b_w = b;
        @(negedge clk);
        while (!in_ready_w && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("w_accept", {63'd0, in_ready_w}, 64'd1);
        @(posedge clk); #1;
        in_valid_w = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check("w_latency", {63'd0, out_valid_w}, {63'd0, (i == 4)});
        end
        check("w_P", {32'd0, P_w}, {32'd0, exp});
        @(posedge clk); #1;
        check("w_release", {63'd0, in_ready_w}, 64'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [7:0]  sa_t [4];
    logic [7:0]  sb_t [4];
    logic [15:0] se_t [4];

    initial begin
        int t;
        logic [15:0] ra, rb;
        logic        rs;
        sa_t = '{8'hFD, 8'h80, 8'h80, 8'h00};
        sb_t = '{8'h05, 8'h80, 8'h01, 8'hF9};
        se_t = '{16'hFFF1, 16'h4000, 16'hFF80, 16'h0000};

        rst = 1'b1;
        in_valid = 1'b0; signed_mode = 1'b0; dataA = '0; dataB = '0;
        in_valid_w = 1'b0; sm_w = 1'b0; a_w = '0; b_w = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_P", {48'd0, P}, 64'd0);
        check("rst_w_in_ready", {63'd0, in_ready_w}, 64'd1);
        check("rst_w_P", {32'd0, P_w}, 64'd0);

        // unsigned maximum: latency and single-cycle out_valid
        send8(1'b0, 8'hFF, 8'hFF);
        lat_check8();
        @(posedge clk); #1;
        check("umax_ov_drop", {63'd0, out_valid}, 64'd0);
        check("umax_in_ready", {63'd0, in_ready}, 64'd1);
        check("umax_P_held", {48'd0, P}, 64'hFE01);

        // signed mixed and extreme
        for (int i = 0; i < 4; i++) begin
            send8(1'b1, sa_t[i], sb_t[i]);
            wait_idle();
            check("signed_P", {48'd0, P}, {48'd0, se_t[i]});
        end

        // back-pressure
        ready_mode = 0;
        send8(1'b0, 8'd12, 8'd13);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_valid_rise", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b1; signed_mode = 1'b0; dataA = 8'd3; dataB = 8'd4;
        for (int i = 0; i < 5; i++) begin
            check("bp_ov_stable", {63'd0, out_valid}, 64'd1);
            check("bp_P_stable", {48'd0, P}, 64'd156);
            check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        ready_mode = 1;
        exp_q.push_back(16'd12);
        n_sent++;
        @(posedge clk); #1;          // output handshake edge
        check("bp_ov_after", {63'd0, out_valid}, 64'd0);
        check("bp_idle_after", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;          // pending pair accepted here
        check("bp_accepted", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        wait_idle();
        check("bp_P_new", {48'd0, P}, 64'd12);

        // reset mid-operation (at step 3 of 8)
        send8(1'b0, 8'd200, 8'd100);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        n_sent--;
        check("mid_rst_ov", {63'd0, out_valid}, 64'd0);
        check("mid_rst_P", {48'd0, P}, 64'd0);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        send8(1'b0, 8'd7, 8'd9);
        lat_check8();
        @(posedge clk); #1;
        check("post_rst_P", {48'd0, P}, 64'd63);

        // radix-16 variant
        run16(1'b0, 16'h1234, 16'hABCD, 32'h0C374FA4);
        run16(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001);
        run16(1'b1, 16'h8000, 16'h8000, 32'h40000000);
        run16(1'b1, 16'h8000, 16'h0001, 32'hFFFF8000);
        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            run16(rs, ra, rb, ref16(rs, ra, rb));
        end

        // randomised regression with stalls on both sides
        ready_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send8(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        check("result_count", 64'(n_res), 64'(n_sent));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mult_hs.md
# seq_mult_hs

Parametrised iterative shift-add multiplier with valid/ready handshakes on both input and output. It retires R multiplier bits per clock and supports run-time signed or unsigned operation. It replaces the fixed 8x8, 1-bit-per-cycle, enable-loaded multiplier in datapaths that need wider operands, higher throughput or signed arithmetic. It sits between an operand producer and a result consumer, and either side may stall.

## Interface
- M, default 8: operand width in bits; must be 2 or more.
- R, default 1: multiplier bits retired per cycle; must be 1, 2 or 4 and must divide M.
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands; equals (state == IDLE).
- signed_mode  input  1  1 means treat dataA/dataB as two's complement; sampled on accept.
- dataA  input  M  multiplicand; sampled on accept.
- dataB  input  M  multiplier; sampled on accept.
- out_valid  output  1  P holds a completed product.
- out_ready  input  1  consumer takes P.
- P  output  2M  product; unsigned, or two's complement when signed_mode was 1.

## Operation
- States: IDLE, CALC, DONE. State encoding is free.
- Accept happens on a clock edge with in_valid && in_ready. On that edge:
  - Latch magA and magB: the absolute values when signed_mode=1, otherwise the raw operands. Both are M-bit unsigned, so -2^(M-1) maps to 2^(M-1).
  - Latch neg = signed_mode & (dataA[M-1] ^ dataB[M-1]).
  - Clear the 2M-bit accumulator and the step counter; go to CALC.
- CALC, step k = 0 .. M/R-1:
  - Partial product = magA * magB[kR +: R], shifted left by kR.
  - Add it into the 2M-bit accumulator; increment k.
  - All arithmetic is modulo 2^2M. The magnitude product is below 2^2M, so the accumulator never overflows.
- Final step (k = M/R-1), in the same edge:
  - P <= neg ? -(acc+pp) : (acc+pp).
  - Go to DONE and set out_valid=1.
- DONE:
  - P and out_valid are held stable until out_ready=1.
  - On the edge with out_valid && out_ready: out_valid<=0 and go to IDLE.
- in_valid is ignored outside IDLE; operands presented during CALC or DONE are not captured.
- Zero product with neg=1 gives P=0; negating zero is harmless.
- Signed extremes: (-2^(M-1))*(-2^(M-1)) = 2^(2M-2), which fits in the 2M-bit signed range.

## Timing
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, P=0, accumulator=0, counter=0.
- rst overrides every other input on the same edge. A reset during CALC or DONE abandons the operation with no result produced.
- Latency: if the accept edge is edge 0, out_valid rises after edge M/R. With the defaults, that is 8 edges.
- Minimum initiation interval: M/R + 2 cycles, covering CALC, one DONE cycle, and one IDLE cycle for the next accept. in_ready is low from the accept edge until the edge after the output handshake.
- The output handshake and the next accept never share an edge, because in_ready is low in DONE.
- P changes only on the final CALC edge and on rst. It is not zeroed when leaving DONE.
- No combinational path from in_valid or out_ready to any output; in_ready depends on state only.

## Test plan
- Unsigned maximum, M=8, R=1: signed_mode=0, A=0xFF, B=0xFF, out_ready=1 -> P=0xFE01 with out_valid high exactly 8 edges after accept, for one cycle; in_ready returns the next cycle.
- Signed mixed and extreme, M=8: -3*5 -> P=0xFFF1; -128*-128 -> P=0x4000; -128*1 -> P=0xFF80; 0*-7 -> P=0x0000.
- Back-pressure: out_ready held 0 for 5 cycles after out_valid -> P and out_valid stable for all 5. in_valid=1 with new operands during that time is not accepted (in_ready=0). After out_ready=1, the new pair is accepted one cycle later.
- Reset mid-operation: assert rst at step 3 of 8 -> next cycle out_valid=0, P=0, in_ready=1. The following 7*9 completes as P=63 with normal latency.
- Radix variant, M=16, R=4: A=0x1234, B=0xABCD unsigned -> P=0x0C374FA4 after 4 edges. Signed -1*-1 -> P=0x00000001.
- Randomised regression: 1000 random operand and mode pairs with random stalls on in_valid and out_ready -> every P matches the reference product, and no operation is lost or duplicated.
